// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst and response encodings
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Error encodings grow with severity, so the worse of two is the larger.
    function automatic resp_e worst_resp(input resp_e a, input resp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mmio_regfile.sv
// mmio_regfile: 64-bit register array, byte-strobed write port, combinational read port
module mmio_regfile #(
    parameter int NREGS = 16,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [63:0]      wdata,
    input  logic [7:0]       wstrb,
    input  logic [IDX_W-1:0] raddr,
    output logic [63:0]      rdata,
    output logic             irq
);

    logic [63:0] regs [NREGS];

    always_ff @(posedge clock) begin
        if (reset)
            regs <= '{default: '0};
        else if (we)
            for (int b = 0; b < 8; b++)
                if (wstrb[b]) regs[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    assign rdata = regs[raddr];
    assign irq   = regs[NREGS-1][0];

endmodule

// File: rtl/mmio_axi_regs.sv
// mmio_axi_regs: AXI4 slave exposing NREGS 64-bit registers, independent
// single-outstanding write and read engines, irq from bit 0 of the last register.
module mmio_axi_regs
    import axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 31,
    parameter int DATA_W = 64,
    parameter int NREGS  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ID_W-1:0]   aw_id,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [7:0]        aw_len,
    input  logic [2:0]        aw_size,
    input  logic [1:0]        aw_burst,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic              w_last,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [ID_W-1:0]   b_id,
    output logic [1:0]        b_resp,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ID_W-1:0]   ar_id,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [7:0]        ar_len,
    input  logic [2:0]        ar_size,
    input  logic [1:0]        ar_burst,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [ID_W-1:0]   r_id,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic              irq
);

    localparam int IDX_W = $clog2(NREGS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e ws, ws_n;
    rstate_e rs, rs_n;

    logic [ID_W-1:0]   wid, rid;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [7:0]        wlen, rlen, wcnt, rcnt;
    logic [2:0]        wsize, rsize;
    logic [1:0]        wburst, rburst;
    resp_e             bresp, w_beat, w_resp, r_beat;
    logic              we;
    logic [63:0]       rd;

    // Anything at or above NREGS*8 has a bit set above the register index field.
    function automatic resp_e beat_resp(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                        input logic [1:0] burst);
        return (|(a >> (IDX_W + 3))) ? RESP_DECERR :
               (burst == BURST_WRAP || size > 3'd3) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size, input logic [1:0] burst);
        return (burst == BURST_INCR) ? a + (ADDR_W'(1) << size) : a;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            ws <= W_IDLE;
            rs <= R_IDLE;
        end else begin
            ws <= ws_n;
            rs <= rs_n;
        end
    end

    always_comb begin
        aw_ready = ws == W_IDLE;
        w_ready  = ws == W_DATA;
        b_valid  = ws == W_RESP;
        w_beat   = beat_resp(waddr, wsize, wburst);
        w_resp   = worst_resp(w_beat, (w_last && wcnt != wlen) ? RESP_SLVERR : RESP_OKAY);
        we       = w_valid && w_ready && w_beat == RESP_OKAY;
        ws_n     = (aw_valid && aw_ready)          ? W_DATA :
                   (w_valid && w_ready && w_last)  ? W_RESP :
                   (b_valid && b_ready)            ? W_IDLE : ws;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wid    <= '0;
            waddr  <= '0;
            wlen   <= '0;
            wsize  <= '0;
            wburst <= '0;
            wcnt   <= '0;
            bresp  <= RESP_OKAY;
        end else if (aw_valid && aw_ready) begin
            wid    <= aw_id;
            waddr  <= aw_addr;
            wlen   <= aw_len;
            wsize  <= aw_size;
            wburst <= aw_burst;
            wcnt   <= '0;
            bresp  <= RESP_OKAY;
        end else if (w_valid && w_ready) begin
            waddr  <= next_addr(waddr, wsize, wburst);
            wcnt   <= wcnt + 8'd1;
            bresp  <= worst_resp(bresp, w_resp);
        end
    end

    assign b_id   = wid;
    assign b_resp = bresp;

    always_comb begin
        ar_ready = rs == R_IDLE;
        r_valid  = rs == R_DATA;
        r_beat   = beat_resp(raddr, rsize, rburst);
        r_last   = r_valid && rcnt == rlen;
        r_resp   = r_valid ? r_beat : RESP_OKAY;
        r_data   = (r_valid && r_beat != RESP_DECERR) ? rd : '0;
        rs_n     = (ar_valid && ar_ready)         ? R_DATA :
                   (r_valid && r_ready && r_last) ? R_IDLE : rs;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rid    <= '0;
            raddr  <= '0;
            rlen   <= '0;
            rsize  <= '0;
            rburst <= '0;
            rcnt   <= '0;
        end else if (ar_valid && ar_ready) begin
            rid    <= ar_id;
            raddr  <= ar_addr;
            rlen   <= ar_len;
            rsize  <= ar_size;
            rburst <= ar_burst;
            rcnt   <= '0;
        end else if (r_valid && r_ready) begin
            raddr  <= next_addr(raddr, rsize, rburst);
            rcnt   <= rcnt + 8'd1;
        end
    end

    assign r_id = rid;

    mmio_regfile #(.NREGS(NREGS)) u_regs (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .waddr (waddr[IDX_W+2:3]),
        .wdata (w_data),
        .wstrb (w_strb),
        .raddr (raddr[IDX_W+2:3]),
        .rdata (rd),
        .irq   (irq)
    );

endmodule

// File: tb/tb_mmio_axi_regs.sv
// tb_mmio_axi_regs: directed bursts checked every cycle against a register-array model
module tb_mmio_axi_regs;

    localparam int ID_W = 4, ADDR_W = 31, DATA_W = 64, NREGS = 16;

    logic clock = 0, reset = 1;
    always #5 clock = ~clock;

    logic aw_valid = 0, aw_ready, w_valid = 0, w_ready, w_last = 0, b_valid, b_ready = 1;
    logic ar_valid = 0, ar_ready, r_valid, r_ready = 1, r_last, irq;
    logic [ID_W-1:0] aw_id = 0, ar_id = 0, b_id, r_id;
    logic [ADDR_W-1:0] aw_addr = 0, ar_addr = 0;
    logic [7:0] aw_len = 0, ar_len = 0, w_strb = 0;
    logic [2:0] aw_size = 0, ar_size = 0;
    logic [1:0] aw_burst = 0, ar_burst = 0, b_resp, r_resp;
    logic [DATA_W-1:0] w_data = 0, r_data;

    mmio_axi_regs #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clock(clock), .reset(reset),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last), .irq(irq)
    );

    typedef struct {logic [ADDR_W-1:0] addr; logic [1:0] resp; logic last; logic [ID_W-1:0] id;} rexp_t;
    typedef struct {logic [ID_W-1:0] id; logic [1:0] resp;} bexp_t;

    int n_chk = 0, n_fail = 0;
    logic [63:0] mdl [NREGS];
    rexp_t exp_r[$];
    bexp_t exp_b[$];
    logic [63:0] rcap[$];
    logic [1:0]  rrcap[$];
    logic        rlcap[$];
    logic [ID_W-1:0] bid_cap;
    logic [1:0]  bresp_cap;
    logic [63:0] wdat [256];
    logic [7:0]  wstb [256];
    logic [63:0] hold_data;
    logic        hold_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
            input logic [2:0] size, input logic [1:0] burst, input int k);
        return (burst == 2'b01) ? base + ADDR_W'(k * (1 << size)) : base;
    endfunction

    function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                             input logic [1:0] burst);
        if (a >= ADDR_W'(NREGS * 8)) return 2'b11;
        if (burst == 2'b10 || size > 3) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [63:0] mdl_rd(input logic [ADDR_W-1:0] a);
        if (a >= ADDR_W'(NREGS * 8)) return 64'd0;
        return mdl[int'(a >> 3)];
    endfunction

    function automatic logic rdy(input int w);
        return (w == 0) ? aw_ready : (w == 1) ? w_ready : ar_ready;
    endfunction

    always @(negedge clock) begin
        if (reset) hold_valid = 0;
        else begin
            chk("irq", irq, mdl[NREGS-1][0]);
            if (r_valid) begin
                if (exp_r.size() == 0) chk("r_unexpected", r_valid, 0);
                else begin
                    chk("r_data", r_data, mdl_rd(exp_r[0].addr));
                    chk("r_resp", r_resp, exp_r[0].resp);
                    chk("r_last", r_last, exp_r[0].last);
                    chk("r_id", r_id, exp_r[0].id);
                    if (hold_valid) chk("r_hold", r_data, hold_data);
                    hold_valid = !r_ready;
                    hold_data = r_data;
                    if (r_ready) begin
                        rcap.push_back(r_data);
                        rrcap.push_back(r_resp);
                        rlcap.push_back(r_last);
                        void'(exp_r.pop_front());
                    end
                end
            end else hold_valid = 0;
            if (b_valid) begin
                if (exp_b.size() == 0) chk("b_unexpected", b_valid, 0);
                else begin
                    chk("b_id", b_id, exp_b[0].id);
                    chk("b_resp", b_resp, exp_b[0].resp);
                    if (b_ready) begin
                        bid_cap = b_id;
                        bresp_cap = b_resp;
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    task automatic hs(input int w);
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (rdy(w)) break;
        end
        chk("handshake_ready", rdy(w), 1);
        @(posedge clock);
        #1;
    endtask

    task automatic axi_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst, input int nbeats);
        bexp_t e;
        logic [1:0] r = 0;
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < nbeats; k++) begin
            logic [1:0] br = beat_resp(beat_addr(addr, size, burst, k), size, burst);
            if (br > r) r = br;
        end
        if (nbeats - 1 != int'(len) && r < 2) r = 2'b10;
        e.id = id;
        e.resp = r;
        exp_b.push_back(e);
        aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        hs(0);
        aw_valid = 0;
        for (int k = 0; k < nbeats; k++) begin
            w_valid = 1; w_data = wdat[k]; w_strb = wstb[k]; w_last = (k == nbeats - 1);
            hs(1);
            a = beat_addr(addr, size, burst, k);
            if (beat_resp(a, size, burst) == 2'b00)
                for (int b = 0; b < 8; b++)
                    if (wstb[k][b]) mdl[int'(a >> 3)][8*b +: 8] = wdat[k][8*b +: 8];
        end
        w_valid = 0;
        w_last = 0;
        @(negedge clock);
        chk("b_latency", b_valid, 1);
        @(posedge clock);
        #1;
        for (int t = 0; t < 50 && exp_b.size() != 0; t++) begin
            @(posedge clock);
            #1;
        end
        chk("b_done", exp_b.size(), 0);
    endtask

    task automatic axi_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
            input bit toggle, input int abort);
        rexp_t e;
        rcap.delete();
        rrcap.delete();
        rlcap.delete();
        for (int k = 0; k <= int'(len); k++) begin
            e.addr = beat_addr(addr, size, burst, k);
            e.resp = beat_resp(e.addr, size, burst);
            e.last = (k == int'(len));
            e.id = id;
            exp_r.push_back(e);
        end
        r_ready = !toggle;
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        hs(2);
        ar_valid = 0;
        @(negedge clock);
        chk("r_latency", r_valid, 1);
        for (int t = 0; t < 2000; t++) begin
            @(posedge clock);
            #1;
            if (exp_r.size() == 0) break;
            if (abort >= 0 && int'(len) + 1 - exp_r.size() == abort) return;
            if (toggle) r_ready = ~r_ready;
        end
        chk("r_done", exp_r.size(), 0);
        r_ready = 1;
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) mdl[i] = 0;
        for (int k = 0; k < 256; k++) wstb[k] = 8'hFF;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_aw_ready", aw_ready, 1);
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_last", r_last, 0);
        chk("rst_resps", {b_resp, r_resp}, 0);
        chk("rst_ids", {b_id, r_id}, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_irq", irq, 0);
        @(posedge clock);
        #1;

        wdat[0] = 64'h1122334455667788;
        axi_write(3, 31'h08, 0, 3, 2'b01, 1);
        chk("single_bid", bid_cap, 3);
        chk("single_bresp", bresp_cap, 0);
        axi_read(5, 31'h08, 0, 3, 2'b01, 0, -1);
        chk("single_rdata", rcap[0], 64'h1122334455667788);
        chk("single_rlast", rlcap[0], 1);

        for (int k = 0; k < 4; k++) wdat[k] = 64'h0101010101010101 * 64'(k + 1);
        axi_write(1, 31'h00, 3, 3, 2'b01, 4);
        axi_read(2, 31'h00, 3, 3, 2'b01, 1, -1);
        chk("incr_beats", rcap.size(), 4);
        chk("incr_beat0", rcap[0], 64'h0101010101010101);
        chk("incr_beat3", rcap[3], 64'h0404040404040404);
        chk("incr_last2", rlcap[2], 0);
        chk("incr_last3", rlcap[3], 1);

        wdat[0] = 64'hDEAD;
        axi_write(4, 31'h80, 0, 3, 2'b01, 1);
        chk("decerr_bresp", bresp_cap, 2'b11);
        axi_read(4, 31'h80, 0, 3, 2'b01, 0, -1);
        chk("decerr_rdata", rcap[0], 0);
        chk("decerr_rresp", rrcap[0], 2'b11);
        axi_read(0, 31'h00, 15, 3, 2'b01, 0, -1);
        chk("all_regs_r1", rcap[1], 64'h0202020202020202);

        wdat[0] = 64'h1;
        axi_write(0, 31'h78, 0, 3, 2'b01, 1);
        chk("irq_set", irq, 1);
        wdat[0] = 64'h0;
        wstb[0] = 8'h01;
        axi_write(0, 31'h78, 0, 3, 2'b01, 1);
        chk("irq_clear", irq, 0);
        wstb[0] = 8'hFF;

        wdat[0] = 64'h5555555555555555;
        wdat[1] = 64'h6666666666666666;
        axi_write(6, 31'h20, 2, 3, 2'b01, 2);
        chk("early_last_bresp", bresp_cap, 2'b10);
        chk("early_last_idle", aw_ready, 1);
        axi_read(6, 31'h20, 1, 3, 2'b01, 0, -1);
        chk("early_last_b0", rcap[0], 64'h5555555555555555);
        chk("early_last_b1", rcap[1], 64'h6666666666666666);

        wdat[0] = 64'hFFFFFFFFFFFFFFFF;
        wstb[0] = 8'h0F;
        axi_write(2, 31'h20, 0, 3, 2'b01, 1);
        wstb[0] = 8'hFF;
        axi_read(2, 31'h20, 0, 3, 2'b01, 0, -1);
        chk("strobe_merge", rcap[0], 64'h55555555FFFFFFFF);

        wdat[0] = 64'h1111111111111111;
        wdat[1] = 64'h2222222222222222;
        axi_write(7, 31'h30, 1, 3, 2'b00, 2);
        axi_read(7, 31'h30, 1, 3, 2'b00, 0, -1);
        chk("fixed_b0", rcap[0], 64'h2222222222222222);
        chk("fixed_b1", rcap[1], 64'h2222222222222222);

        axi_write(8, 31'h38, 1, 3, 2'b10, 2);
        chk("wrap_bresp", bresp_cap, 2'b10);
        axi_write(8, 31'h38, 0, 4, 2'b01, 1);
        chk("size4_bresp", bresp_cap, 2'b10);
        axi_read(8, 31'h38, 0, 3, 2'b10, 0, -1);
        chk("wrap_read_data", rcap[0], 0);
        chk("wrap_read_resp", rrcap[0], 2'b10);

        axi_read(9, 31'h78, 1, 3, 2'b01, 0, -1);
        chk("cross_resp0", rrcap[0], 2'b00);
        chk("cross_resp1", rrcap[1], 2'b11);

        for (int k = 0; k < 256; k++) wdat[k] = 64'(k);
        axi_write(10, 31'h30, 255, 3, 2'b00, 256);
        chk("len255_bresp", bresp_cap, 0);
        axi_read(10, 31'h30, 255, 3, 2'b00, 0, -1);
        chk("len255_beats", rcap.size(), 256);
        chk("len255_data", rcap[255], 64'd255);
        chk("len255_last254", rlcap[254], 0);
        chk("len255_last255", rlcap[255], 1);

        axi_read(11, 31'h00, 3, 3, 2'b01, 0, 2);
        reset = 1;
        r_ready = 0;
        exp_r.delete();
        exp_b.delete();
        for (int i = 0; i < NREGS; i++) mdl[i] = 0;
        @(posedge clock);
        @(negedge clock);
        chk("abort_r_valid", r_valid, 0);
        chk("abort_ar_ready", ar_ready, 1);
        chk("abort_irq", irq, 0);
        @(posedge clock);
        #1;
        reset = 0;
        r_ready = 1;
        axi_read(12, 31'h08, 0, 3, 2'b01, 0, -1);
        chk("abort_reg_cleared", rcap[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_axi_regs.md
MMIO_AXI_REGS -- requirements
Module: mmio_axi_regs

Interface
REQ-001 Parameter ID_W, default 4: AXI ID width.
REQ-002 Parameter ADDR_W, default 31: AXI address width.
REQ-003 Parameter DATA_W, default 64: data width; fixed at 64, strobe width 8.
REQ-004 Parameter NREGS, default 16: number of 64-bit registers; power of two.
REQ-005 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  single clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 AW channel: aw_valid in 1; aw_ready out 1; aw_id in ID_W; aw_addr in ADDR_W; aw_len in 8; aw_size in 3; aw_burst in 2. lock/cache/prot/qos are accepted and ignored.
REQ-009 W channel: w_valid in 1; w_ready out 1; w_data in 64; w_strb in 8; w_last in 1.
REQ-010 B channel: b_valid out 1; b_ready in 1; b_id out ID_W; b_resp out 2.
REQ-011 AR channel: ar_valid in 1; ar_ready out 1; ar_id in ID_W; ar_addr in ADDR_W; ar_len in 8; ar_size in 3; ar_burst in 2.
REQ-012 R channel: r_valid out 1; r_ready in 1; r_id out ID_W; r_data out 64; r_resp out 2; r_last out 1.
REQ-013 irq  out  1  level interrupt, equal to bit 0 of register NREGS-1.

Function
REQ-014 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP, with one outstanding write.
REQ-015 In W_IDLE: aw_ready=1; on AW handshake, latch id/addr/len/size/burst, clear the beat counter, and go to W_DATA.
REQ-016 In W_DATA: w_ready=1; each W handshake writes the lanes selected by w_strb into register addr[3+log2(NREGS)-1:3], then advances the address.
REQ-017 Address advance: INCR adds 1<<size; FIXED holds the address.
REQ-018 A W handshake with w_last=1 SHALL go to W_RESP.
REQ-019 In W_RESP: b_valid=1 and b_id is the latched id; hold both until b_ready, then return to W_IDLE; back-to-back AW is accepted the cycle after.
REQ-020 b_resp SHALL be OKAY, except that the following SHALL set it sticky for the burst:
  - DECERR (2'b11) if any beat address >= NREGS*8; that beat's register write is suppressed.
  - SLVERR (2'b10) if burst is WRAP, size>3, or the w_last beat index != len; the write of a WRAP/size>3 beat is suppressed.
  - DECERR takes priority over SLVERR.
REQ-021 Read FSM states SHALL be R_IDLE and R_DATA, with one outstanding read, independent of the write FSM.
REQ-022 In R_IDLE: ar_ready=1; on AR handshake, latch the fields and go to R_DATA the next cycle.
REQ-023 In R_DATA: r_valid=1; r_data is the current register value (0 for a decode error); r_last=1 when the beat counter equals len.
REQ-024 The R payload SHALL be stable while r_valid && !r_ready; the address advances on each handshake per REQ-017.
REQ-025 The last R handshake SHALL return to R_IDLE.
REQ-026 r_resp per beat uses the REQ-020 rules, without the w_last condition.
REQ-027 First-beat latency SHALL be: AR handshake at cycle N gives r_valid at N+1; the bresp appears the cycle after the w_last handshake.
REQ-028 A same-cycle write and read to the same register SHALL return the old value; the new value is visible from the next cycle.
REQ-029 The beat counter is 8 bits; len=255 gives 256 beats with no wrap-around error.

Reset
REQ-030 On reset, both FSMs SHALL go idle: aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, r_last=0, b_resp/r_resp=0, ids=0, r_data=0.
REQ-031 On reset, all registers SHALL be 0, so irq=0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst with no B/R response; a master must also reset.

Structure
REQ-033 A shared axi_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP) and resp encodings (OKAY/EXOKAY/SLVERR/DECERR).
REQ-034 The register array SHALL be one sub-module, mmio_regfile, with a byte-strobed write port and a combinational read port.

Verification
REQ-035 Single write of 0x1122334455667788 at 0x08, strb 0xFF, id 3 -> b_id=3, b_resp=OKAY; a read of 0x08 returns the same data with r_last=1.
REQ-036 INCR write len=3, size=3 from 0x00, then read len=3 with r_ready toggling every other cycle -> 4 beats in order, payload held while stalled, r_last only on beat 3.
REQ-037 Write to 0x80 (NREGS=16) -> b_resp=DECERR, no register changes; read 0x80 -> r_data=0, r_resp=DECERR.
REQ-038 Write 0x1 to 0x78 -> irq=1 the next cycle; write strb 0x01 with data 0 -> irq=0.
REQ-039 W burst aw_len=2 with w_last on beat 1 -> b_resp=SLVERR, beats 0-1 written, FSM back in W_IDLE.
REQ-040 Reset asserted during R_DATA beat 2 of 4 -> r_valid=0 the next cycle; the subsequent read of any register returns 0.
